// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: FSM encoding and default sizing.
// Defaults give a 1 ms gate at 100 MHz, so the result reads directly in kHz.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } fm_state_t;

    localparam int DEF_GATE_CYCLES = 100000;
    localparam int DEF_COUNT_WIDTH = 20;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus one delay stage; emits a one-cycle pulse on each
// rising edge of an asynchronous input. Also used for buttons and external pins.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic edge_pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES clk
// cycles and publishes the result with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sig_in,
    input  logic                   start,
    input  logic                   cont,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow,
    output logic                   valid
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]      GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(
        input logic [COUNT_WIDTH-1:0] v,
        input logic                   inc
    );
        if (inc && (v != CNT_MAX))
            return v + COUNT_WIDTH'(1);
        return v;
    endfunction

    function automatic logic sat_hit(
        input logic [COUNT_WIDTH-1:0] v,
        input logic                   inc
    );
        return inc && (v == CNT_MAX);
    endfunction

    fm_state_t              state;
    fm_state_t              state_nxt;
    logic [GATE_W-1:0]      gate_cnt;
    logic [GATE_W-1:0]      gate_nxt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [COUNT_WIDTH-1:0] ecnt_nxt;
    logic                   sat_q;
    logic                   sat_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic                   ovf_nxt;
    logic                   vld_p1;
    logic                   vld_nxt;
    logic                   edge_p0;

    sync_edge_det u_sync (
        .clk        (clk),
        .rst        (rst),
        .d          (sig_in),
        .edge_pulse (edge_p0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat_q    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            gate_cnt <= gate_nxt;
            edge_cnt <= ecnt_nxt;
            sat_q    <= sat_nxt;
            count    <= count_nxt;
            overflow <= ovf_nxt;
            vld_p1   <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gate_nxt  = gate_cnt;
        ecnt_nxt  = edge_cnt;
        sat_nxt   = sat_q;
        count_nxt = count;
        ovf_nxt   = overflow;
        vld_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GATE;
                    gate_nxt  = GATE_LOAD;
                    ecnt_nxt  = '0;
                    sat_nxt   = 1'b0;
                end
            end
            GATE: begin
                if (gate_cnt == '0) begin
                    // Fold the final cycle's edge into the result so back-to-back
                    // windows lose nothing at the boundary.
                    count_nxt = sat_inc(edge_cnt, edge_p0);
                    ovf_nxt   = sat_q | sat_hit(edge_cnt, edge_p0);
                    vld_nxt   = 1'b1;
                    ecnt_nxt  = '0;
                    sat_nxt   = 1'b0;
                    if (cont) begin
                        gate_nxt = GATE_LOAD;
                    end else begin
                        gate_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    ecnt_nxt = sat_inc(edge_cnt, edge_p0);
                    sat_nxt  = sat_q | sat_hit(edge_cnt, edge_p0);
                    gate_nxt = gate_cnt - GATE_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == GATE);
    assign valid = vld_p1;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (wide counter and 6-bit counter)
// share all inputs; sig_in comes from a free-running generator with real-valued delays.
module tb_freq_meter;
    timeunit 1ns;
    timeprecision 1ps;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic        cont;
    logic        busy_m;
    logic [19:0] count_m;
    logic        ovf_m;
    logic        valid_m;
    logic        busy_s;
    logic [5:0]  count_s;
    logic        ovf_s;
    logic        valid_s;

    int  checks = 0;
    int  errors = 0;
    int  mode   = 0;      // 0: stuck low, 1: stuck high, 2: toggling
    real half_ns = 50.0;

    longint c_m;
    longint c_s;
    longint o_m;
    longint o_s;

    freq_meter #(.GATE_CYCLES(1000), .COUNT_WIDTH(20)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy_m), .count(count_m), .overflow(ovf_m), .valid(valid_m)
    );

    freq_meter #(.GATE_CYCLES(1000), .COUNT_WIDTH(6)) dut_sat (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy_s), .count(count_s), .overflow(ovf_s), .valid(valid_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sig_in = 1'b0;
        forever begin
            if (mode == 2) begin
                #(half_ns);
                sig_in = ~sig_in;
            end else begin
                #1;
                sig_in = (mode == 1);
            end
        end
    end

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol = 0);
        longint diff;
        diff = (got > exp) ? (got - exp) : (exp - got);
        checks++;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
        end
    endtask

    // One single-shot measurement; optional extra start pulse at cycle poke_at.
    task automatic measure(input string tag, input int poke_at);
        int n;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                check({tag, "_busy_rise"}, busy_m, 1);
            end
            if (poke_at > 0 && n == poke_at) start = 1'b1;
            if (poke_at > 0 && n == poke_at + 1) start = 1'b0;
        end while (!valid_m && n < 3000);
        check({tag, "_latency"}, n, 1001);
        check({tag, "_busy_fall"}, busy_m, 0);
        check({tag, "_sat_valid"}, valid_s, 1);
        c_m = count_m;
        c_s = count_s;
        o_m = ovf_m;
        o_s = ovf_s;
        @(negedge clk);
        check({tag, "_strobe_len"}, valid_m, 0);
    endtask

    real    halfs[4] = '{14.70588, 28.57143, 41.66667, 100.0};
    longint exps[4]  = '{340, 175, 120, 50};

    initial begin
        int n;
        int vcount;
        int busy_drop;
        rst   = 1'b1;
        start = 1'b0;
        cont  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_m, 0);
        check("rst_valid", valid_m, 0);
        check("rst_count", count_m, 0);
        check("rst_ovf", ovf_m, 0);
        rst = 1'b0;

        // 10 MHz: exact count and saturation of the 6-bit instance
        mode = 2;
        half_ns = 50.0;
        repeat (20) @(negedge clk);
        measure("f10", 0);
        check("f10_count", c_m, 100, 1);
        check("f10_ovf", o_m, 0);
        check("sat_count", c_s, 63);
        check("sat_ovf", o_s, 1);

        for (int i = 0; i < 4; i++) begin
            half_ns = halfs[i];
            repeat (20) @(negedge clk);
            measure($sformatf("pll%0d", i), 0);
            check($sformatf("pll%0d_count", i), c_m, exps[i], 1);
            check($sformatf("pll%0d_ovf", i), o_m, 0);
        end

        // 1 MHz: saturation clears in the next window
        half_ns = 500.0;
        repeat (20) @(negedge clk);
        measure("f1", 0);
        check("f1_count", c_m, 10, 1);
        check("f1_sat_count", c_s, 10, 1);
        check("f1_sat_ovf", o_s, 0);

        // Continuous mode at 10 MHz
        half_ns = 50.0;
        repeat (20) @(negedge clk);
        cont = 1'b1;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        busy_drop = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end while (!valid_m && n < 3000);
        check("cont_first", n, 1001);
        for (int w = 0; w < 3; w++) begin
            if (w == 2) cont = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!valid_m && !busy_m) busy_drop++;
            end while (!valid_m && n < 3000);
            check($sformatf("cont_period%0d", w), n, 1000);
            check($sformatf("cont_count%0d", w), count_m, 100, 1);
        end
        check("cont_no_busy_drop", busy_drop, 0);
        check("cont_stop_busy", busy_m, 0);

        // Start pulsed mid-window is ignored
        repeat (5) @(negedge clk);
        measure("midstart", 500);
        check("midstart_count", c_m, 100, 1);

        // Reset at gate cycle 500 aborts the window
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        check("abort_pre_busy", busy_m, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_m, 0);
        check("abort_count", count_m, 0);
        check("abort_ovf", ovf_m, 0);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (valid_m) vcount++;
        end
        check("abort_no_valid", vcount, 0);

        // Stuck low
        mode = 0;
        repeat (10) @(negedge clk);
        measure("stuck0", 0);
        check("stuck0_count", c_m, 0);

        // Stuck high through a reset release, no window open at the time
        mode = 1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        measure("stuck1", 0);
        check("stuck1_count", c_m, 0);
        check("stuck1_sat_count", c_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
